// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: serial scan picks retrigger / lowest free / oldest voice.
// Optional damper pedal support is compiled in with `define SUSTAIN_EN.
module voice_alloc #(
  parameter int NVOICES = 6,
  parameter int NOTE_W  = 7
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef SUSTAIN_EN
  input  logic                      sustain,
`endif
  input  logic                      ev_valid,
  output logic                      ev_ready,
  input  logic                      ev_on,
  input  logic [NOTE_W-1:0]         ev_note,
  input  logic [NOTE_W-1:0]         ev_vel,
  output logic [NVOICES-1:0]        gate,
  output logic [NVOICES*NOTE_W-1:0] note_out,
  output logic                      steal
);

  localparam int IW = (NVOICES > 1) ? $clog2(NVOICES) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RETRIG} state_t;

  state_t                      state_reg;
  logic [IW-1:0]               idx_reg;
  logic                        on_reg;
  logic [NOTE_W-1:0]           ev_note_reg;
  logic                        match_found_reg, free_found_reg;
  logic [IW-1:0]               match_idx_reg, free_idx_reg, old_idx_reg, tgt_reg;
  logic [NVOICES-1:0]          voice_gate_reg;
  logic [NOTE_W-1:0]           voice_note_reg [NVOICES];
  logic [IW-1:0]               rank_reg [NVOICES];
  logic [NVOICES-1:0]          gate_out_reg;
  logic [NVOICES*NOTE_W-1:0]   note_out_reg;
  logic [NVOICES*NOTE_W-1:0]   note_flat;
  logic                        steal_reg;
  logic [IW-1:0]               tgt_idx;
`ifdef SUSTAIN_EN
  logic [NVOICES-1:0]          sus_reg;
  logic                        sustain_d_reg;
  logic                        release_pend_reg;

  // A pending pedal release owns the next IDLE cycle.
  assign ev_ready = (state_reg == IDLE) && !rst && !release_pend_reg;
`else
  assign ev_ready = (state_reg == IDLE) && !rst;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NVOICES; gi++) begin : g_flat
      assign note_flat[gi*NOTE_W +: NOTE_W] = voice_note_reg[gi];
    end
  endgenerate

  always_comb begin
    tgt_idx = old_idx_reg;
    if (match_found_reg)     tgt_idx = match_idx_reg;
    else if (free_found_reg) tgt_idx = free_idx_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      on_reg          <= 1'b0;
      ev_note_reg     <= '0;
      match_found_reg <= 1'b0;
      free_found_reg  <= 1'b0;
      match_idx_reg   <= '0;
      free_idx_reg    <= '0;
      old_idx_reg     <= '0;
      tgt_reg         <= '0;
      voice_gate_reg  <= '0;
      gate_out_reg    <= '0;
      note_out_reg    <= '0;
      steal_reg       <= 1'b0;
      for (int i = 0; i < NVOICES; i++) begin
        voice_note_reg[i] <= '0;
        rank_reg[i]       <= IW'(i);
      end
`ifdef SUSTAIN_EN
      sus_reg          <= '0;
      sustain_d_reg    <= 1'b0;
      release_pend_reg <= 1'b0;
`endif
    end else begin
      steal_reg    <= 1'b0;
      gate_out_reg <= voice_gate_reg;
      note_out_reg <= note_flat;
      case (state_reg)
        IDLE: begin
`ifdef SUSTAIN_EN
          if (release_pend_reg) begin
            voice_gate_reg   <= voice_gate_reg & ~sus_reg;
            gate_out_reg     <= voice_gate_reg & ~sus_reg;
            sus_reg          <= '0;
            release_pend_reg <= 1'b0;
          end else
`endif
          if (ev_valid && ev_ready) begin
            on_reg          <= ev_on && (ev_vel != '0);
            ev_note_reg     <= ev_note;
            match_found_reg <= 1'b0;
            free_found_reg  <= 1'b0;
            idx_reg         <= '0;
            state_reg       <= SCAN;
          end
        end
        SCAN: begin
          if (voice_gate_reg[idx_reg] && voice_note_reg[idx_reg] == ev_note_reg && !match_found_reg) begin
            match_found_reg <= 1'b1;
            match_idx_reg   <= idx_reg;
          end
          // Sustained voices keep gate high, so they are never seen as free.
          if (!voice_gate_reg[idx_reg] && !free_found_reg) begin
            free_found_reg <= 1'b1;
            free_idx_reg   <= idx_reg;
          end
          if (rank_reg[idx_reg] == IW'(NVOICES-1))
            old_idx_reg <= idx_reg;
          if (idx_reg == IW'(NVOICES-1)) state_reg <= COMMIT;
          else                           idx_reg   <= idx_reg + 1'b1;
        end
        COMMIT: begin
          state_reg <= IDLE;
          if (on_reg) begin
            voice_note_reg[tgt_idx] <= ev_note_reg;
            for (int i = 0; i < NVOICES; i++) begin
              if (IW'(i) == tgt_idx)                rank_reg[i] <= '0;
              else if (rank_reg[i] < rank_reg[tgt_idx]) rank_reg[i] <= rank_reg[i] + 1'b1;
            end
            steal_reg <= !match_found_reg && !free_found_reg;
`ifdef SUSTAIN_EN
            sus_reg[tgt_idx] <= 1'b0;
`endif
            // A held target drops for one cycle so the operator sees a fresh edge.
            if (voice_gate_reg[tgt_idx]) begin
              voice_gate_reg[tgt_idx] <= 1'b0;
              tgt_reg                 <= tgt_idx;
              state_reg               <= RETRIG;
            end else begin
              voice_gate_reg[tgt_idx] <= 1'b1;
            end
          end else if (match_found_reg) begin
`ifdef SUSTAIN_EN
            if (sustain) sus_reg[match_idx_reg]        <= 1'b1;
            else         voice_gate_reg[match_idx_reg] <= 1'b0;
`else
            voice_gate_reg[match_idx_reg] <= 1'b0;
`endif
          end
        end
        RETRIG: begin
          voice_gate_reg[tgt_reg] <= 1'b1;
          state_reg               <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
`ifdef SUSTAIN_EN
      sustain_d_reg <= sustain;
      if (sustain_d_reg && !sustain)
        release_pend_reg <= 1'b1;
`endif
    end
  end

  assign gate     = gate_out_reg;
  assign note_out = note_out_reg;
  assign steal    = steal_reg;

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc (NVOICES=6, NOTE_W=7); sustain scenario only with SUSTAIN_EN.
module tb_voice_alloc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic        ev_on = 1'b0;
  logic [6:0]  ev_note = '0;
  logic [6:0]  ev_vel = '0;
  logic [5:0]  gate;
  logic [41:0] note_out;
  logic        steal;
`ifdef SUSTAIN_EN
  logic        sustain = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  voice_alloc #(.NVOICES(6), .NOTE_W(7)) dut (
    .clk(clk),
    .rst(rst),
`ifdef SUSTAIN_EN
    .sustain(sustain),
`endif
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_on(ev_on),
    .ev_note(ev_note),
    .ev_vel(ev_vel),
    .gate(gate),
    .note_out(note_out),
    .steal(steal)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one event and returns 1 ns after the accepting edge (edge 0).
  task automatic send(input logic on, input logic [6:0] n, input logic [6:0] v);
    bit done = 0;
    ev_on = on; ev_note = n; ev_vel = v; ev_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      if (ev_ready) done = 1;
      step(1);
    end
    ev_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout note=%0d got no ev_ready, required ev_ready=1", n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic fill_60_65();
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 7'(60 + i), 7'd100);
      step(8);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    checks++;
    if (gate !== 6'b0 || note_out !== 42'b0 || steal !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs gate=%b note_out=%h steal=%b, required all zero", gate, note_out, steal);
    end
    checks++;
    if (ev_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready ev_ready=%b, required 0 while rst high", ev_ready);
    end
    rst = 1'b0;
    step(1);
    checks++;
    if (ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset ev_ready=%b, required 1", ev_ready);
    end
  endtask

  task automatic test_free_noteon();
    int steals = 0;
    send(1'b1, 7'd60, 7'd100);
    for (int k = 1; k <= 7; k++) begin
      step(1);
      steals += int'(steal);
    end
    checks++;
    if (gate !== 6'b000000) begin
      errors++;
      $display("FAIL free_latency_e7 gate=%b, required 000000", gate);
    end
    step(1);
    steals += int'(steal);
    checks++;
    if (gate !== 6'b000001 || note_out[6:0] !== 7'd60) begin
      errors++;
      $display("FAIL free_noteon_e8 gate=%b note0=%0d, required 000001 / 60", gate, note_out[6:0]);
    end
    checks++;
    if (ev_ready !== 1'b1 || steals !== 0) begin
      errors++;
      $display("FAIL free_ready_steal ev_ready=%b steals=%0d, required 1 / 0", ev_ready, steals);
    end
  endtask

  task automatic test_fill_and_steal();
    logic [5:0] g7, g8, g9;
    int steals;
    do_reset();
    fill_60_65();
    checks++;
    if (gate !== 6'b111111 || note_out !== {7'd65, 7'd64, 7'd63, 7'd62, 7'd61, 7'd60}) begin
      errors++;
      $display("FAIL fill gate=%b note_out=%h, required 111111 with notes 65..60", gate, note_out);
    end
    // Oldest is voice 0, then voice 1 after the first steal.
    for (int s = 0; s < 2; s++) begin
      steals = 0;
      send(1'b1, 7'(70 + s), 7'd90);
      for (int k = 1; k <= 9; k++) begin
        step(1);
        steals += int'(steal);
        if (k == 7) g7 = gate;
        if (k == 8) g8 = gate;
        if (k == 9) g9 = gate;
      end
      checks++;
      if (steals !== 1) begin
        errors++;
        $display("FAIL steal_pulse_%0d steal_cycles=%0d, required 1", s, steals);
      end
      checks++;
      if (g7 !== 6'b111111 || g8 !== (6'b111111 & ~(6'b1 << s)) || g9 !== 6'b111111) begin
        errors++;
        $display("FAIL steal_gate_%0d e7=%b e8=%b e9=%b, required 111111 / voice %0d low / 111111", s, g7, g8, g9, s);
      end
      checks++;
      if (note_out[s*7 +: 7] !== 7'(70 + s)) begin
        errors++;
        $display("FAIL steal_note_%0d note=%0d, required %0d", s, note_out[s*7 +: 7], 70 + s);
      end
    end
  endtask

  task automatic test_release_and_reuse();
    int steals = 0;
    do_reset();
    fill_60_65();
    send(1'b0, 7'd62, 7'd0);
    step(8);
    checks++;
    if (gate !== 6'b111011 || note_out[20:14] !== 7'd62) begin
      errors++;
      $display("FAIL noteoff_62 gate=%b note2=%0d, required 111011 / 62", gate, note_out[20:14]);
    end
    send(1'b1, 7'd80, 7'd50);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      steals += int'(steal);
    end
    checks++;
    if (gate !== 6'b111111 || note_out !== {7'd65, 7'd64, 7'd63, 7'd80, 7'd61, 7'd60} || steals !== 0) begin
      errors++;
      $display("FAIL reuse_80 gate=%b note_out=%h steals=%0d, required 111111 / voice2=80 / 0", gate, note_out, steals);
    end
  endtask

  task automatic test_retrigger();
    logic [5:0] g7, g8, g9;
    int steals = 0;
    send(1'b1, 7'd64, 7'd127);
    for (int k = 1; k <= 9; k++) begin
      step(1);
      steals += int'(steal);
      if (k == 7) g7 = gate;
      if (k == 8) g8 = gate;
      if (k == 9) g9 = gate;
    end
    checks++;
    if (g7 !== 6'b111111 || g8 !== 6'b101111 || g9 !== 6'b111111) begin
      errors++;
      $display("FAIL retrig_gate e7=%b e8=%b e9=%b, required 111111 / 101111 / 111111", g7, g8, g9);
    end
    checks++;
    if (steals !== 0 || note_out !== {7'd65, 7'd64, 7'd63, 7'd80, 7'd61, 7'd60}) begin
      errors++;
      $display("FAIL retrig_other steals=%0d note_out=%h, required 0 / unchanged", steals, note_out);
    end
  endtask

  task automatic test_vel0_and_unmatched();
    logic r6;
    send(1'b1, 7'd61, 7'd0);
    step(8);
    checks++;
    if (gate !== 6'b111101 || note_out[13:7] !== 7'd61) begin
      errors++;
      $display("FAIL vel0_release gate=%b note1=%0d, required 111101 / 61", gate, note_out[13:7]);
    end
    send(1'b0, 7'd99, 7'd0);
    step(6);
    r6 = ev_ready;
    step(2);
    checks++;
    if (r6 !== 1'b0 || ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL unmatched_ready e6=%b e8=%b, required 0 / 1", r6, ev_ready);
    end
    checks++;
    if (gate !== 6'b111101 || note_out !== {7'd65, 7'd64, 7'd63, 7'd80, 7'd61, 7'd60}) begin
      errors++;
      $display("FAIL unmatched_noop gate=%b note_out=%h, required no change", gate, note_out);
    end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    send(1'b1, 7'd40, 7'd100);
    step(3);
    rst = 1'b1;
    step(1);
    checks++;
    if (gate !== 6'b0 || note_out !== 42'b0 || ev_ready !== 1'b0) begin
      errors++;
      $display("FAIL midscan_reset gate=%b note_out=%h ev_ready=%b, required 0 / 0 / 0", gate, note_out, ev_ready);
    end
    rst = 1'b0;
    step(10);
    checks++;
    if (gate !== 6'b0 || ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL event_dropped gate=%b ev_ready=%b, required 000000 / 1", gate, ev_ready);
    end
  endtask

`ifdef SUSTAIN_EN
  task automatic test_sustain();
    do_reset();
    sustain = 1'b1;
    send(1'b1, 7'd60, 7'd100);
    step(8);
    send(1'b0, 7'd60, 7'd0);
    step(8);
    checks++;
    if (gate !== 6'b000001) begin
      errors++;
      $display("FAIL sustain_hold gate=%b, required 000001", gate);
    end
    sustain = 1'b0;
    step(1);
    checks++;
    if (ev_ready !== 1'b0) begin
      errors++;
      $display("FAIL sustain_release_ready ev_ready=%b, required 0", ev_ready);
    end
    step(1);
    checks++;
    if (gate !== 6'b000000) begin
      errors++;
      $display("FAIL sustain_release gate=%b, required 000000", gate);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_free_noteon();
    test_fill_and_steal();
    test_release_and_reuse();
    test_retrigger();
    test_vel0_and_unmatched();
    test_reset_mid_scan();
`ifdef SUSTAIN_EN
    test_sustain();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
